beam_threshold_ctrl: RTL and testbench

Configuration controller for the beamform/square trigger datapath: holds per-beam power thresholds and beam masks in a shadow bank written through a simple write port, and transfers the whole bank atomically into the active bank that drives the threshold comparators. The transfer happens only on a trigger-period boundary (`trig_sync_i`), so comparators never see a mix of old and new thresholds. The block sits between the register/control interface and the per-beam comparators that consume the squared beam sums.

---
 rtl/beam_threshold_pkg.sv | 30 +++
 rtl/beam_cfg_bank.sv | 36 +++
 rtl/beam_threshold_ctrl.sv | 135 +++++++++++++
 tb/tb_beam_threshold_ctrl.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/beam_threshold_pkg.sv
// Shared types and constants for the beam threshold configuration controller.
package beam_threshold_pkg;

    localparam int unsigned NBEAMS = 48;
    localparam int unsigned THBITS = 18;
    localparam int unsigned ADDR_W = $clog2(NBEAMS);
    localparam int unsigned CFG_W  = THBITS + 1;

    typedef logic [THBITS-1:0] thresh_t;

    typedef struct packed {
        logic    mask;
        thresh_t th;
    } beam_cfg_t;

    localparam thresh_t   THRESH_RESET   = {THBITS{1'b1}};
    localparam beam_cfg_t BEAM_CFG_RESET = '{mask: 1'b1, th: THRESH_RESET};

    typedef enum logic [1:0] {
        IDLE,
        WAIT_SYNC,
        ACK
    } state_t;

    // True when a configuration address names an existing beam.
    function automatic logic addr_valid(input logic [ADDR_W-1:0] addr);
        return 32'(addr) < NBEAMS;
    endfunction

endpackage

// File: rtl/beam_cfg_bank.sv
// One beam's shadow/active configuration register pair.
module beam_cfg_bank
    import beam_threshold_pkg::*;
(
    input  logic      clk_i,
    input  logic      rst_n_i,
    input  logic      wr_en_i,
    input  beam_cfg_t wr_data_i,
    input  logic      load_i,
    output beam_cfg_t active_o
);

    beam_cfg_t r_shadow;
    beam_cfg_t r_active;

    // Shadow register: written from the configuration port.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_shadow <= BEAM_CFG_RESET;
        end else if (wr_en_i) begin
            r_shadow <= wr_data_i;
        end
    end

    // Active register: takes the shadow copy when the bank transfer fires.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_active <= BEAM_CFG_RESET;
        end else if (load_i) begin
            r_active <= r_shadow;
        end
    end

    assign active_o = r_active;

endmodule

// File: rtl/beam_threshold_ctrl.sv
// Beam threshold/mask controller: shadow bank written through the cfg port,
// copied atomically into the active bank on a trigger-period boundary.
// Optional feature: BEAM_THRESH_TIMEOUT_EN forces the transfer after TIMEOUT
// cycles without a sync and reports it on upd_timeout_o.
module beam_threshold_ctrl
    import beam_threshold_pkg::*;
`ifdef BEAM_THRESH_TIMEOUT_EN
#(
    parameter int unsigned TIMEOUT = 1024
)
`endif
(
    input  logic                     clk_i,
    input  logic                     rst_n_i,
    input  logic                     cfg_wr_i,
    input  logic [ADDR_W-1:0]        cfg_addr_i,
    input  logic [THBITS:0]          cfg_data_i,
    output logic                     cfg_ready_o,
    input  logic                     upd_req_i,
    output logic                     upd_ack_o,
    input  logic                     trig_sync_i,
    output logic [NBEAMS*THBITS-1:0] thresh_o,
    output logic [NBEAMS-1:0]        mask_o,
    output logic                     upd_overrun_o,
    output logic                     upd_timeout_o
);

    state_t    r_state;
    logic      r_ready;
    logic      r_ack;
    logic      r_overrun;
    logic      w_cfg_ok;
    logic      w_expire;
    logic      w_load;
    beam_cfg_t w_wr_data;
    beam_cfg_t w_active [NBEAMS];

`ifdef BEAM_THRESH_TIMEOUT_EN
    localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    logic [CNT_W-1:0] r_cnt;
    logic             r_timeout;

    // Expiry only counts when no sync arrives in the same cycle.
    assign w_expire = (r_state == WAIT_SYNC) && (r_cnt == '0) && !trig_sync_i;

    // Sync wait down-counter and sticky forced-transfer flag.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_cnt     <= '0;
            r_timeout <= 1'b0;
        end else begin
            if (r_state == IDLE && upd_req_i) begin
                r_cnt <= CNT_W'(TIMEOUT - 1);
            end else if (r_state == WAIT_SYNC && r_cnt != '0) begin
                r_cnt <= r_cnt - CNT_W'(1);
            end
            if (w_expire) begin
                r_timeout <= 1'b1;
            end
        end
    end

    assign upd_timeout_o = r_timeout;
`else
    assign w_expire      = 1'b0;
    assign upd_timeout_o = 1'b0;
`endif

    // Writes are taken only in IDLE and only for existing beams.
    assign w_cfg_ok  = cfg_wr_i && (r_state == IDLE) && addr_valid(cfg_addr_i);
    assign w_wr_data = beam_cfg_t'(cfg_data_i);
    assign w_load    = (r_state == WAIT_SYNC) && (trig_sync_i || w_expire);

    // Transfer control FSM with registered ready/ack and sticky overrun flag.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state   <= IDLE;
            r_ready   <= 1'b1;
            r_ack     <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_ack <= 1'b0;
            if (upd_req_i && r_state != IDLE) begin
                r_overrun <= 1'b1;
            end
            case (r_state)
                IDLE: begin
                    if (upd_req_i) begin
                        r_state <= WAIT_SYNC;
                        r_ready <= 1'b0;
                    end
                end
                WAIT_SYNC: begin
                    if (w_load) begin
                        r_state <= ACK;
                        r_ack   <= 1'b1;
                    end
                end
                ACK: begin
                    r_state <= IDLE;
                    r_ready <= 1'b1;
                end
                default: begin
                    r_state <= IDLE;
                    r_ready <= 1'b1;
                end
            endcase
        end
    end

    assign cfg_ready_o   = r_ready;
    assign upd_ack_o     = r_ack;
    assign upd_overrun_o = r_overrun;

    // Per-beam register pairs and flattened active outputs.
    for (genvar b = 0; b < NBEAMS; b++) begin : g_beam
        logic w_wr_en;

        assign w_wr_en = w_cfg_ok && (cfg_addr_i == ADDR_W'(b));

        beam_cfg_bank u_bank (
            .clk_i     (clk_i),
            .rst_n_i   (rst_n_i),
            .wr_en_i   (w_wr_en),
            .wr_data_i (w_wr_data),
            .load_i    (w_load),
            .active_o  (w_active[b])
        );

        assign thresh_o[THBITS*b +: THBITS] = w_active[b].th;
        assign mask_o[b]                    = w_active[b].mask;
    end

endmodule

// File: tb/tb_beam_threshold_ctrl.sv
// Directed self-checking bench for beam_threshold_ctrl with a transfer scoreboard.
module tb_beam_threshold_ctrl;
    import beam_threshold_pkg::*;

    typedef logic [NBEAMS*CFG_W-1:0] snap_t;

    logic                     clk;
    logic                     rst_n;
    logic                     cfg_wr;
    logic [ADDR_W-1:0]        cfg_addr;
    logic [THBITS:0]          cfg_data;
    logic                     cfg_ready;
    logic                     upd_req;
    logic                     upd_ack;
    logic                     trig_sync;
    logic [NBEAMS*THBITS-1:0] thresh;
    logic [NBEAMS-1:0]        mask;
    logic                     ovr;
    logic                     tmo;

    int tests = 0;
    int fails = 0;

    beam_cfg_t m_shadow [NBEAMS];
    beam_cfg_t m_active [NBEAMS];
    int        m_state;
    logic      m_ovr;
    logic      m_tmo;
    snap_t     sb_q [$];

`ifdef BEAM_THRESH_TIMEOUT_EN
    localparam int TMO = 16;
    int m_cnt;

    beam_threshold_ctrl #(.TIMEOUT(TMO)) dut (
        .clk_i(clk), .rst_n_i(rst_n), .cfg_wr_i(cfg_wr), .cfg_addr_i(cfg_addr),
        .cfg_data_i(cfg_data), .cfg_ready_o(cfg_ready), .upd_req_i(upd_req),
        .upd_ack_o(upd_ack), .trig_sync_i(trig_sync), .thresh_o(thresh),
        .mask_o(mask), .upd_overrun_o(ovr), .upd_timeout_o(tmo)
    );
`else
    beam_threshold_ctrl dut (
        .clk_i(clk), .rst_n_i(rst_n), .cfg_wr_i(cfg_wr), .cfg_addr_i(cfg_addr),
        .cfg_data_i(cfg_data), .cfg_ready_o(cfg_ready), .upd_req_i(upd_req),
        .upd_ack_o(upd_ack), .trig_sync_i(trig_sync), .thresh_o(thresh),
        .mask_o(mask), .upd_overrun_o(ovr), .upd_timeout_o(tmo)
    );
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Compare every beam on the DUT outputs against a packed expected bank.
    task automatic check_bank(input string tag, input snap_t exp);
        int bad = -1;
        logic [CFG_W-1:0] o = '0;
        logic [CFG_W-1:0] e = '0;
        for (int b = 0; b < NBEAMS; b++) begin
            if (bad < 0 && {mask[b], thresh[THBITS*b +: THBITS]} !== exp[CFG_W*b +: CFG_W]) begin
                bad = b;
                o = {mask[b], thresh[THBITS*b +: THBITS]};
                e = exp[CFG_W*b +: CFG_W];
            end
        end
        tests++;
        assert (bad < 0) else begin
            fails++;
            $error("FAIL %s: beam %0d observed %0h expected %0h", tag, bad, o, e);
        end
    endtask

    function automatic snap_t pack_bank(input beam_cfg_t bank [NBEAMS]);
        snap_t s;
        for (int b = 0; b < NBEAMS; b++) s[CFG_W*b +: CFG_W] = bank[b];
        return s;
    endfunction

    function automatic snap_t reset_snap();
        snap_t s;
        for (int b = 0; b < NBEAMS; b++) s[CFG_W*b +: CFG_W] = {1'b1, {THBITS{1'b1}}};
        return s;
    endfunction

    task automatic model_reset();
        for (int b = 0; b < NBEAMS; b++) begin
            m_shadow[b] = beam_cfg_t'({1'b1, {THBITS{1'b1}}});
            m_active[b] = beam_cfg_t'({1'b1, {THBITS{1'b1}}});
        end
        m_state = 0;
        m_ovr   = 1'b0;
        m_tmo   = 1'b0;
        sb_q.delete();
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_ready"}, 64'(cfg_ready), 64'(1));
        check({tag, "_ack"}, 64'(upd_ack), 64'(0));
        check({tag, "_mask"}, 64'(mask), {16'h0, {NBEAMS{1'b1}}});
        check({tag, "_ovr"}, 64'(ovr), 64'(0));
        check({tag, "_tmo"}, 64'(tmo), 64'(0));
        check_bank({tag, "_bank"}, reset_snap());
    endtask

    // Advance one clock: step the reference model on the driven inputs, then check.
    task automatic tick();
        logic go;
        snap_t exp_s;
        go = 1'b0;
        if (m_state == 0 && cfg_wr && 32'(cfg_addr) < NBEAMS)
            m_shadow[cfg_addr] = beam_cfg_t'(cfg_data);
        if (m_state != 0 && upd_req) m_ovr = 1'b1;
        case (m_state)
            0: if (upd_req) begin
                m_state = 1;
`ifdef BEAM_THRESH_TIMEOUT_EN
                m_cnt = TMO - 1;
`endif
                sb_q.push_back(pack_bank(m_shadow));
            end
            1: begin
                if (trig_sync) go = 1'b1;
`ifdef BEAM_THRESH_TIMEOUT_EN
                else if (m_cnt == 0) begin
                    go    = 1'b1;
                    m_tmo = 1'b1;
                end else m_cnt--;
`endif
                if (go) begin
                    m_active = m_shadow;
                    m_state  = 2;
                end
            end
            default: m_state = 0;
        endcase
        @(posedge clk);
        #1;
        check("ready", 64'(cfg_ready), 64'(m_state == 0));
        check("ack", 64'(upd_ack), 64'(m_state == 2));
        check("overrun", 64'(ovr), 64'(m_ovr));
        check("timeout", 64'(tmo), 64'(m_tmo));
        check_bank("active", pack_bank(m_active));
        if (upd_ack === 1'b1) begin
            if (sb_q.size() == 0) begin
                check("ack_unexpected", 64'(upd_ack), 64'(0));
            end else begin
                exp_s = sb_q.pop_front();
                check_bank("sb_transfer", exp_s);
            end
        end
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        rst_n     = 1'b0;
        cfg_wr    = 1'b0;
        cfg_addr  = '0;
        cfg_data  = '0;
        upd_req   = 1'b0;
        trig_sync = 1'b0;
        model_reset();
        #17;
        check_reset_vals("rst_hold");
        #15;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_reset_vals("rst_rel");

        // Sync while idle does nothing.
        trig_sync = 1'b1; tick(); trig_sync = 1'b0;

        // Basic update of beam 5, sync 10 cycles after the request.
        cfg_wr = 1'b1; cfg_addr = 6'd5; cfg_data = {1'b0, 18'h00400}; tick();
        cfg_wr = 1'b0; upd_req = 1'b1; tick(); upd_req = 1'b0;
        ticks(9);
        trig_sync = 1'b1; tick(); trig_sync = 1'b0;
        check("b5_thresh", 64'(thresh[THBITS*5 +: THBITS]), 64'h00400);
        check("b5_mask", 64'(mask[5]), 64'(0));
        check("b5_ack", 64'(upd_ack), 64'(1));
        tick();
        check("b5_ack_drop", 64'(upd_ack), 64'(0));
        tick();

        // Write stall: beam 7 written during WAIT_SYNC is dropped.
        upd_req = 1'b1; tick(); upd_req = 1'b0;
        cfg_wr = 1'b1; cfg_addr = 6'd7; cfg_data = {1'b0, 18'h00123}; tick();
        cfg_wr = 1'b0;
        trig_sync = 1'b1; tick(); trig_sync = 1'b0;
        ticks(2);
        check("b7_kept", 64'(thresh[THBITS*7 +: THBITS]), 64'h3FFFF);

        // Write + request + sync together: sync ignored, next sync transfers beam 0.
        cfg_wr = 1'b1; cfg_addr = 6'd0; cfg_data = {1'b0, 18'h2AAAA};
        upd_req = 1'b1; trig_sync = 1'b1; tick();
        cfg_wr = 1'b0; upd_req = 1'b0; trig_sync = 1'b0;
        ticks(3);
        trig_sync = 1'b1; tick(); trig_sync = 1'b0;
        check("b0_thresh", 64'(thresh[THBITS*0 +: THBITS]), 64'h2AAAA);
        ticks(2);

        // Out-of-range address is ignored, ready stays high.
        cfg_wr = 1'b1; cfg_addr = 6'd50; cfg_data = {1'b0, 18'h00001}; tick();
        cfg_wr = 1'b0;

        // Second request in flight sets overrun; minimum latency transfer.
        cfg_wr = 1'b1; cfg_addr = 6'd47; cfg_data = {1'b1, 18'h0ABCD}; tick();
        cfg_wr = 1'b0; upd_req = 1'b1; tick();
        tick();
        check("ovr_set", 64'(ovr), 64'(1));
        upd_req = 1'b0; trig_sync = 1'b1; tick(); trig_sync = 1'b0;
        check("b47_thresh", 64'(thresh[THBITS*47 +: THBITS]), 64'h0ABCD);
        ticks(2);

        // Minimum request-to-ack latency of 2 cycles.
        upd_req = 1'b1; tick(); upd_req = 1'b0;
        trig_sync = 1'b1; tick(); trig_sync = 1'b0;
        check("min_lat_ack", 64'(upd_ack), 64'(1));
        ticks(2);

`ifdef BEAM_THRESH_TIMEOUT_EN
        // Forced transfer when no sync arrives.
        begin
            int k = 0;
            cfg_wr = 1'b1; cfg_addr = 6'd3; cfg_data = {1'b0, 18'h00777}; tick();
            cfg_wr = 1'b0; upd_req = 1'b1; tick(); upd_req = 1'b0;
            while (upd_ack !== 1'b1 && k < 40) begin
                tick();
                k++;
            end
            check("tmo_latency", 64'(k), 64'(TMO));
            check("tmo_flag", 64'(tmo), 64'(1));
            ticks(2);
        end
`endif

        // Reset during WAIT_SYNC: immediate return to reset values, no ack.
        cfg_wr = 1'b1; cfg_addr = 6'd9; cfg_data = {1'b0, 18'h00055}; tick();
        cfg_wr = 1'b0; upd_req = 1'b1; tick(); upd_req = 1'b0;
        tick();
        #3;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_reset_vals("rst_async");
        trig_sync = 1'b1;
        @(posedge clk);
        #1;
        check_reset_vals("rst_held");
        trig_sync = 1'b0;
        rst_n = 1'b1;
        ticks(3);
        check("sb_empty", 64'(sb_q.size()), 64'(0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
